id_rf_bypass: RTL and testbench

- ID-stage consumer of the write-back bus, i.e. the receiving end of wb_to_rf_bus.
- Holds the 32x32 GPR file and the HI/LO pair, and commits WB writes.
- Serves two GPR read ports and HI/LO reads, with forwarding from EX, MEM and WB.
- Raises a load-use stall request to the stall controller.

---
 rtl/id_rf_bypass_pkg.sv | 48 ++++
 rtl/id_rf_bypass_if.sv | 39 +++
 rtl/id_rf_bypass_rf_array.sv | 36 +++
 rtl/id_rf_bypass.sv | 66 ++++++
 tb/tb_id_rf_bypass.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/id_rf_bypass_pkg.sv
// id_rf_bypass_pkg
// Shared widths, bus layouts and the GPR forwarding helper for the ID-stage
// register file with EX/MEM/WB bypass.
//   rf_wr_t   : {we, waddr[4:0], wdata[31:0]}         (38 bits)
//   hilo_wr_t : {hi_we, lo_we, hi[31:0], lo[31:0]}    (66 bits)
package id_rf_bypass_pkg;

    localparam int RF_DEPTH     = 32;
    localparam int DATA_W       = 32;
    localparam int RF_AW        = 5;

    localparam int WB_TO_RF_WD  = 1 + RF_AW + DATA_W;
    localparam int EX_TO_ID_WD  = 1 + RF_AW + DATA_W;
    localparam int MEM_TO_ID_WD = 1 + RF_AW + DATA_W;
    localparam int HILO_BUS_WD  = 2 + 2 * DATA_W;

    typedef struct packed {
        logic              we;
        logic [RF_AW-1:0]  waddr;
        logic [DATA_W-1:0] wdata;
    } rf_wr_t;

    typedef struct packed {
        logic              hi_we;
        logic              lo_we;
        logic [DATA_W-1:0] hi;
        logic [DATA_W-1:0] lo;
    } hilo_wr_t;

    // One read port: $0 first, then youngest producer wins, then the array.
    function automatic logic [DATA_W-1:0] fwd_gpr(
        input logic              re,
        input logic [RF_AW-1:0]  raddr,
        input rf_wr_t            ex,
        input rf_wr_t            mem,
        input rf_wr_t            wb,
        input logic [DATA_W-1:0] arr
    );
        logic [DATA_W-1:0] r;
        if (!re || raddr == '0)                  r = '0;
        else if (ex.we  && ex.waddr  == raddr)   r = ex.wdata;
        else if (mem.we && mem.waddr == raddr)   r = mem.wdata;
        else if (wb.we  && wb.waddr  == raddr)   r = wb.wdata;
        else                                     r = arr;
        return r;
    endfunction

endpackage

// File: rtl/id_rf_bypass_if.sv
// id_rf_bypass_if
// Bundles the pipeline buses, read ports and results of the ID register file.
//   master : pipeline side (drives buses, read requests; sees results)
//   slave  : register file side
interface id_rf_bypass_if;
    import id_rf_bypass_pkg::*;

    logic [WB_TO_RF_WD-1:0]  wb_to_rf_bus;
    logic [MEM_TO_ID_WD-1:0] mem_to_id_bus;
    logic [EX_TO_ID_WD-1:0]  ex_to_id_bus;
    logic                    ex_is_load;
    logic [HILO_BUS_WD-1:0]  wb_hilo_bus;
    logic [HILO_BUS_WD-1:0]  mem_hilo_bus;
    logic [HILO_BUS_WD-1:0]  ex_hilo_bus;
    logic                    re1;
    logic                    re2;
    logic [RF_AW-1:0]        raddr1;
    logic [RF_AW-1:0]        raddr2;
    logic [DATA_W-1:0]       rdata1;
    logic [DATA_W-1:0]       rdata2;
    logic [DATA_W-1:0]       hi_o;
    logic [DATA_W-1:0]       lo_o;
    logic                    stallreq_for_load;

    modport master (
        output wb_to_rf_bus, mem_to_id_bus, ex_to_id_bus, ex_is_load,
               wb_hilo_bus, mem_hilo_bus, ex_hilo_bus,
               re1, re2, raddr1, raddr2,
        input  rdata1, rdata2, hi_o, lo_o, stallreq_for_load
    );

    modport slave (
        input  wb_to_rf_bus, mem_to_id_bus, ex_to_id_bus, ex_is_load,
               wb_hilo_bus, mem_hilo_bus, ex_hilo_bus,
               re1, re2, raddr1, raddr2,
        output rdata1, rdata2, hi_o, lo_o, stallreq_for_load
    );

endinterface

// File: rtl/id_rf_bypass_rf_array.sv
// rf_array
// 32x32 GPR storage: one synchronous write port, two asynchronous read ports,
// $0 reads as zero and ignores writes. Synchronous active-high clear.
//   clk, rst          : clock, synchronous reset
//   we, waddr, wdata  : write port
//   raddr1/2, rdata1/2: asynchronous read ports
module rf_array
    import id_rf_bypass_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [RF_AW-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [RF_AW-1:0]  raddr1,
    input  logic [RF_AW-1:0]  raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2
);

    logic [DATA_W-1:0] regs [RF_DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RF_DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (we && waddr != '0) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
    assign rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];

endmodule

// File: rtl/id_rf_bypass.sv
// id_rf_bypass
// ID-stage register file: commits WB writes to the GPR array and HI/LO,
// serves two GPR reads and HI/LO with EX > MEM > WB > register forwarding,
// and requests a one-cycle stall on a load-use hazard.
//   clk, rst : clock, synchronous active-high reset
//   bus      : id_rf_bypass_if.slave (pipeline buses, read ports, results)
module id_rf_bypass
    import id_rf_bypass_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    id_rf_bypass_if.slave  bus
);

    rf_wr_t   wb, mem_b, ex;
    hilo_wr_t wb_hl, mem_hl, ex_hl;

    assign wb     = rf_wr_t'(bus.wb_to_rf_bus);
    assign mem_b  = rf_wr_t'(bus.mem_to_id_bus);
    assign ex     = rf_wr_t'(bus.ex_to_id_bus);
    assign wb_hl  = hilo_wr_t'(bus.wb_hilo_bus);
    assign mem_hl = hilo_wr_t'(bus.mem_hilo_bus);
    assign ex_hl  = hilo_wr_t'(bus.ex_hilo_bus);

    logic [DATA_W-1:0] arr_rd1, arr_rd2;
    logic [DATA_W-1:0] hi_r, lo_r;

    rf_array u_rf_array (
        .clk    (clk),
        .rst    (rst),
        .we     (wb.we),
        .waddr  (wb.waddr),
        .wdata  (wb.wdata),
        .raddr1 (bus.raddr1),
        .raddr2 (bus.raddr2),
        .rdata1 (arr_rd1),
        .rdata2 (arr_rd2)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_r <= '0;
            lo_r <= '0;
        end else begin
            if (wb_hl.hi_we) hi_r <= wb_hl.hi;
            if (wb_hl.lo_we) lo_r <= wb_hl.lo;
        end
    end

    assign bus.rdata1 = fwd_gpr(bus.re1, bus.raddr1, ex, mem_b, wb, arr_rd1);
    assign bus.rdata2 = fwd_gpr(bus.re2, bus.raddr2, ex, mem_b, wb, arr_rd2);

    // HI and LO resolve independently of each other.
    assign bus.hi_o = ex_hl.hi_we  ? ex_hl.hi  :
                      mem_hl.hi_we ? mem_hl.hi :
                      wb_hl.hi_we  ? wb_hl.hi  : hi_r;
    assign bus.lo_o = ex_hl.lo_we  ? ex_hl.lo  :
                      mem_hl.lo_we ? mem_hl.lo :
                      wb_hl.lo_we  ? wb_hl.lo  : lo_r;

    // Load data in EX is not yet available; the next cycle it forwards from MEM.
    assign bus.stallreq_for_load = bus.ex_is_load & ex.we & (ex.waddr != '0) &
                                   ((bus.re1 & (bus.raddr1 == ex.waddr)) |
                                    (bus.re2 & (bus.raddr2 == ex.waddr)));

endmodule

// File: tb/tb_id_rf_bypass.sv
module tb_id_rf_bypass;
    import id_rf_bypass_pkg::*;

    logic clk;
    logic rst;

    logic        wb_we,  mem_we,  ex_we;
    logic [4:0]  wb_a,   mem_a,   ex_a;
    logic [31:0] wb_d,   mem_d,   ex_d;
    logic        ex_is_load;
    logic        wh_we, wl_we, mh_we, ml_we, eh_we, el_we;
    logic [31:0] wh, wl, mh, ml, eh, el;
    logic        re1, re2;
    logic [4:0]  ra1, ra2;

    id_rf_bypass_if bus_if ();

    assign bus_if.wb_to_rf_bus  = {wb_we, wb_a, wb_d};
    assign bus_if.mem_to_id_bus = {mem_we, mem_a, mem_d};
    assign bus_if.ex_to_id_bus  = {ex_we, ex_a, ex_d};
    assign bus_if.ex_is_load    = ex_is_load;
    assign bus_if.wb_hilo_bus   = {wh_we, wl_we, wh, wl};
    assign bus_if.mem_hilo_bus  = {mh_we, ml_we, mh, ml};
    assign bus_if.ex_hilo_bus   = {eh_we, el_we, eh, el};
    assign bus_if.re1           = re1;
    assign bus_if.re2           = re2;
    assign bus_if.raddr1        = ra1;
    assign bus_if.raddr2        = ra2;

    id_rf_bypass dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    // mask bits: 0 rdata1, 1 rdata2, 2 hi_o, 3 lo_o, 4 stall
    typedef struct {
        logic [31:0] r1, r2, hi, lo;
        logic        st;
        logic [4:0]  m;
    } exp_t;

    exp_t  q[$];
    string nq[$];
    int    vectors     = 0;
    int    miscompares = 0;
    logic [31:0] model [32];

    task automatic cmp(input string n, input logic [31:0] act, input logic [31:0] exp_v);
        vectors++;
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", n, act, exp_v);
        end
    endtask

    // Monitor: outputs are combinational, so a pushed expectation is checked
    // mid-cycle after the stimulus has settled.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t  e;
            string nm;
            e  = q.pop_front();
            nm = nq.pop_front();
            if (e.m[0]) cmp({nm, ".rdata1"}, bus_if.rdata1, e.r1);
            if (e.m[1]) cmp({nm, ".rdata2"}, bus_if.rdata2, e.r2);
            if (e.m[2]) cmp({nm, ".hi_o"},   bus_if.hi_o,   e.hi);
            if (e.m[3]) cmp({nm, ".lo_o"},   bus_if.lo_o,   e.lo);
            if (e.m[4]) cmp({nm, ".stall"},  {31'b0, bus_if.stallreq_for_load}, {31'b0, e.st});
        end
    end

    task automatic expect_v(input string n, input logic [4:0] m,
                            input logic [31:0] r1, input logic [31:0] r2,
                            input logic [31:0] hi, input logic [31:0] lo,
                            input logic st);
        exp_t e;
        e.r1 = r1; e.r2 = r2; e.hi = hi; e.lo = lo; e.st = st; e.m = m;
        q.push_back(e);
        nq.push_back(n);
    endtask

    task automatic clear_in();
        rst = 0;
        wb_we = 0; wb_a = 0; wb_d = 0;
        mem_we = 0; mem_a = 0; mem_d = 0;
        ex_we = 0; ex_a = 0; ex_d = 0;
        ex_is_load = 0;
        wh_we = 0; wl_we = 0; wh = 0; wl = 0;
        mh_we = 0; ml_we = 0; mh = 0; ml = 0;
        eh_we = 0; el_we = 0; eh = 0; el = 0;
        re1 = 0; re2 = 0; ra1 = 0; ra2 = 0;
    endtask

    task automatic tick();
        if (rst) begin
            for (int i = 0; i < 32; i++) model[i] = '0;
        end else if (wb_we && wb_a != 0) begin
            model[wb_a] = wb_d;
        end
        @(posedge clk);
        #1;
        clear_in();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = '0;
        clear_in();

        // reset with a WB write pending: the write must be dropped
        rst = 1; wb_we = 1; wb_a = 5; wb_d = 32'hDEAD;
        tick();
        rst = 1; wb_we = 1; wb_a = 5; wb_d = 32'hDEAD;
        tick();

        re1 = 1; ra1 = 5;
        expect_v("reset_r5", 5'b11101, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        tick();

        // commit and same-cycle bypass
        wb_we = 1; wb_a = 3; wb_d = 32'h12345678; re1 = 1; ra1 = 3;
        expect_v("wb_bypass", 5'b00001, 32'h12345678, 0, 0, 0, 0);
        tick();
        re1 = 1; ra1 = 3; re2 = 1; ra2 = 3;
        expect_v("commit_r3", 5'b00011, 32'h12345678, 32'h12345678, 0, 0, 0);
        tick();

        // $0 hardwired
        wb_we = 1; wb_a = 0; wb_d = 32'hFFFFFFFF; re1 = 1; ra1 = 0;
        expect_v("r0_wr", 5'b00001, 32'h0, 0, 0, 0, 0);
        tick();
        re1 = 1; ra1 = 0;
        expect_v("r0_rd", 5'b00001, 32'h0, 0, 0, 0, 0);
        tick();

        // priority EX > MEM > WB
        ex_we = 1; ex_a = 8; ex_d = 32'hA;
        mem_we = 1; mem_a = 8; mem_d = 32'hB;
        wb_we = 1; wb_a = 8; wb_d = 32'hC;
        re1 = 1; ra1 = 8; re2 = 1; ra2 = 8;
        expect_v("prio_ex", 5'b00011, 32'hA, 32'hA, 0, 0, 0);
        tick();
        mem_we = 1; mem_a = 8; mem_d = 32'hB;
        wb_we = 1; wb_a = 8; wb_d = 32'hC;
        re1 = 1; ra1 = 8;
        expect_v("prio_mem", 5'b00001, 32'hB, 0, 0, 0, 0);
        tick();
        wb_we = 1; wb_a = 8; wb_d = 32'hC; re1 = 1; ra1 = 8;
        expect_v("prio_wb", 5'b00001, 32'hC, 0, 0, 0, 0);
        tick();
        ex_we = 1; ex_a = 8; ex_d = 32'hA; re1 = 0; ra1 = 8; re2 = 1; ra2 = 3;
        expect_v("re_off", 5'b00011, 32'h0, 32'h12345678, 0, 0, 0);
        tick();

        // load-use
        ex_is_load = 1; ex_we = 1; ex_a = 9; ex_d = 32'h99; re2 = 1; ra2 = 9;
        expect_v("lu_re2", 5'b10000, 0, 0, 0, 0, 1'b1);
        tick();
        ex_is_load = 1; ex_we = 1; ex_a = 9; ex_d = 32'h99; re2 = 0; ra2 = 9;
        expect_v("lu_re_off", 5'b10000, 0, 0, 0, 0, 1'b0);
        tick();
        ex_is_load = 1; ex_we = 1; ex_a = 0; re2 = 1; ra2 = 0;
        expect_v("lu_r0", 5'b10000, 0, 0, 0, 0, 1'b0);
        tick();
        ex_is_load = 1; ex_we = 1; ex_a = 9; re1 = 1; ra1 = 9;
        expect_v("lu_re1", 5'b10000, 0, 0, 0, 0, 1'b1);
        tick();
        ex_is_load = 0; ex_we = 1; ex_a = 9; ex_d = 32'h77; re1 = 1; ra1 = 9;
        expect_v("lu_notload", 5'b10001, 32'h77, 0, 0, 0, 1'b0);
        tick();
        mem_we = 1; mem_a = 9; mem_d = 32'h55; re2 = 1; ra2 = 9;
        expect_v("lu_mem", 5'b10010, 0, 32'h55, 0, 0, 1'b0);
        tick();

        // HI/LO
        wl_we = 1; wl = 32'h7; wh = 32'hBAD;
        expect_v("lo_bypass", 5'b01100, 0, 0, 32'h0, 32'h7, 0);
        tick();
        expect_v("lo_commit", 5'b01100, 0, 0, 32'h0, 32'h7, 0);
        tick();
        eh_we = 1; eh = 32'h1; el = 32'hEEE;
        expect_v("hi_ex_split", 5'b01100, 0, 0, 32'h1, 32'h7, 0);
        tick();
        eh_we = 1; eh = 32'h1; mh_we = 1; mh = 32'h22; ml_we = 1; ml = 32'h33;
        expect_v("hilo_mix", 5'b01100, 0, 0, 32'h1, 32'h33, 0);
        tick();
        wh_we = 1; wh = 32'hABC; wl = 32'h999;
        tick();
        expect_v("hi_commit", 5'b01100, 0, 0, 32'hABC, 32'h7, 0);
        tick();

        // bubbles with random reads
        for (int i = 0; i < 10; i++) begin
            logic [4:0] a1, a2;
            a1 = 5'($urandom_range(0, 31));
            a2 = 5'($urandom_range(0, 31));
            re1 = 1; ra1 = a1; re2 = 1; ra2 = a2;
            expect_v("bubble", 5'b10011, model[a1], model[a2], 0, 0, 1'b0);
            tick();
        end

        // mid-stream reset
        rst = 1; wb_we = 1; wb_a = 8; wb_d = 32'h77; wh_we = 1; wh = 32'h5;
        tick();
        re1 = 1; ra1 = 8; re2 = 1; ra2 = 3;
        expect_v("rst_mid", 5'b01111, 32'h0, 32'h0, 32'h0, 32'h0, 0);
        tick();

        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
